// File: rtl/mmio_counters_if.sv
// Pipeline-side signals for the performance counters: event pulses, the clearing
// store, the writeback read select, and the counter values going back to the core.
interface mmio_counters_if #(
  parameter int W_SIZE = 32
);
  logic              inst_retired;
  logic              br_resolved;
  logic              br_correct;
  logic              store_en_m;
  logic [W_SIZE-1:0] store_addr_m;
  logic [3:0]        wb_sel_m;
  logic              stall;
  logic [W_SIZE-1:0] cnt_rdata_w;
  logic [W_SIZE-1:0] cyc_count;
  logic [W_SIZE-1:0] inst_count;
  logic [W_SIZE-1:0] br_count;
  logic [W_SIZE-1:0] corr_br_count;

  modport master (
    output inst_retired, br_resolved, br_correct, store_en_m, store_addr_m,
           wb_sel_m, stall,
    input  cnt_rdata_w, cyc_count, inst_count, br_count, corr_br_count
  );

  modport slave (
    input  inst_retired, br_resolved, br_correct, store_en_m, store_addr_m,
           wb_sel_m, stall,
    output cnt_rdata_w, cyc_count, inst_count, br_count, corr_br_count
  );
endinterface

// File: rtl/mmio_counters.sv
// Four wrapping performance counters cleared by an MMIO store, plus a stall-aware
// memory-to-writeback read register feeding the writeback mux.
module mmio_counters #(
  parameter int                W_SIZE   = 32,
  parameter logic [W_SIZE-1:0] RST_ADDR = 32'h80000018
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_counters_if.slave bus
);

  localparam logic [W_SIZE-1:0] ONE     = 1;
  localparam logic [3:0]        SEL_CYC = 4'd6;
  localparam logic [3:0]        SEL_INS = 4'd7;
  localparam logic [3:0]        SEL_BR  = 4'd8;
  localparam logic [3:0]        SEL_COR = 4'd9;

  logic [W_SIZE-1:0] cyc_q,   cyc_d;
  logic [W_SIZE-1:0] inst_q,  inst_d;
  logic [W_SIZE-1:0] br_q,    br_d;
  logic [W_SIZE-1:0] corr_q,  corr_d;
  logic [W_SIZE-1:0] rdata_q, rdata_d;
  logic              clear_hit;

  function automatic logic [W_SIZE-1:0] sel_count(
    input logic [3:0]        sel,
    input logic [W_SIZE-1:0] cyc,
    input logic [W_SIZE-1:0] inst,
    input logic [W_SIZE-1:0] br,
    input logic [W_SIZE-1:0] corr
  );
    case (sel)
      SEL_CYC: return cyc;
      SEL_INS: return inst;
      SEL_BR:  return br;
      SEL_COR: return corr;
      default: return '0;
    endcase
  endfunction

  // Full-width compare so byte aliases of the clear address are ignored.
  assign clear_hit = bus.store_en_m && (bus.store_addr_m == RST_ADDR);

  always_comb begin
    cyc_d   = cyc_q + ONE;
    inst_d  = inst_q + (bus.inst_retired ? ONE : '0);
    br_d    = br_q + (bus.br_resolved ? ONE : '0);
    corr_d  = corr_q + ((bus.br_resolved && bus.br_correct) ? ONE : '0);
    rdata_d = rdata_q;
    // A clear drops any events arriving in the same cycle.
    if (clear_hit) begin
      cyc_d  = '0;
      inst_d = '0;
      br_d   = '0;
      corr_d = '0;
    end
    if (!bus.stall) begin
      rdata_d = sel_count(bus.wb_sel_m, cyc_q, inst_q, br_q, corr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      inst_q  <= '0;
      br_q    <= '0;
      corr_q  <= '0;
      rdata_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
      br_q    <= br_d;
      corr_q  <= corr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.cyc_count     = cyc_q;
  assign bus.inst_count    = inst_q;
  assign bus.br_count      = br_q;
  assign bus.corr_br_count = corr_q;
  assign bus.cnt_rdata_w   = rdata_q;

endmodule

// File: tb/tb_mmio_counters.sv
// Randomized and directed bench for mmio_counters against an event-level count model.
module tb_mmio_counters;

  localparam logic [31:0] RST_ADDR = 32'h80000018;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] m_cnt[4];
  logic [31:0] m_rd;

  mmio_counters_if #(.W_SIZE(32)) bus ();

  mmio_counters #(.W_SIZE(32), .RST_ADDR(RST_ADDR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("cyc",   bus.cyc_count,     m_cnt[0]);
    chk("inst",  bus.inst_count,    m_cnt[1]);
    chk("br",    bus.br_count,      m_cnt[2]);
    chk("corr",  bus.corr_br_count, m_cnt[3]);
    chk("rdata", bus.cnt_rdata_w,   m_rd);
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    m_rd = '0;
  endtask

  task automatic idle();
    bus.inst_retired = 1'b0;
    bus.br_resolved  = 1'b0;
    bus.br_correct   = 1'b0;
    bus.store_en_m   = 1'b0;
    bus.store_addr_m = '0;
    bus.wb_sel_m     = 4'd0;
    bus.stall        = 1'b0;
  endtask

  // One clock edge: advance the model from the pre-edge inputs, then compare.
  task automatic tick();
    int sel;
    @(posedge clk);
    sel = int'(bus.wb_sel_m);
    if (!bus.stall) m_rd = (sel >= 6 && sel <= 9) ? m_cnt[sel-6] : 32'd0;
    if (bus.store_en_m && bus.store_addr_m == RST_ADDR) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else begin
      m_cnt[0] = m_cnt[0] + 32'd1;
      if (bus.inst_retired) m_cnt[1] = m_cnt[1] + 32'd1;
      if (bus.br_resolved) m_cnt[2] = m_cnt[2] + 32'd1;
      if (bus.br_resolved && bus.br_correct) m_cnt[3] = m_cnt[3] + 32'd1;
    end
    #1;
    chk_all();
  endtask

  task automatic rand_inputs(input bit allow_store);
    int r;
    bus.inst_retired = 1'($urandom_range(0, 1));
    bus.br_resolved  = 1'($urandom_range(0, 1));
    bus.br_correct   = 1'($urandom_range(0, 1));
    bus.stall        = ($urandom_range(0, 3) == 0);
    bus.wb_sel_m     = 4'($urandom_range(0, 15));
    bus.store_en_m   = 1'b0;
    bus.store_addr_m = $urandom();
    if (allow_store) begin
      r = $urandom_range(0, 19);
      bus.store_en_m = (r < 4);
      if (r == 0) bus.store_addr_m = RST_ADDR;
      else if (r == 1) bus.store_addr_m = RST_ADDR + 32'd1;
      else if (r == 2) bus.store_addr_m = RST_ADDR + 32'd4;
      else if (r == 4) bus.store_addr_m = RST_ADDR;
    end
  endtask

  task automatic do_clear();
    idle();
    bus.store_en_m   = 1'b1;
    bus.store_addr_m = RST_ADDR;
    tick();
    idle();
  endtask

  initial begin
    idle();
    model_zero();
    rst_n = 1'b0;
    #2;
    chk_all();
    #10 rst_n = 1'b1;

    // Random warm-up, then asynchronous reset mid-cycle.
    for (int i = 0; i < 50; i++) begin
      rand_inputs(1'b0);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    model_zero();
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 10; i++) tick();
    chk("cyc_after_reset", bus.cyc_count, 32'd10);
    chk("inst_after_reset", bus.inst_count, 32'd0);

    // Event counting with stray br_correct pulses.
    do_clear();
    for (int i = 0; i < 9; i++) begin
      bus.inst_retired = (i < 7);
      bus.br_resolved  = (i < 5);
      bus.br_correct   = (i < 3) || (i >= 7);
      tick();
    end
    idle();
    chk("inst_7", bus.inst_count, 32'd7);
    chk("br_5", bus.br_count, 32'd5);
    chk("corr_3", bus.corr_br_count, 32'd3);

    // Clear collides with events; next-cycle load of the cycle counter sees 0.
    bus.inst_retired = 1'b1;
    bus.br_resolved  = 1'b1;
    bus.br_correct   = 1'b1;
    bus.store_en_m   = 1'b1;
    bus.store_addr_m = RST_ADDR;
    tick();
    chk("clr_cyc", bus.cyc_count, 32'd0);
    chk("clr_inst", bus.inst_count, 32'd0);
    idle();
    bus.wb_sel_m     = 4'd6;
    bus.store_en_m   = 1'b1;
    bus.store_addr_m = 32'h8000001C;
    tick();
    chk("load_after_clr", bus.cnt_rdata_w, 32'd0);
    chk("other_addr_cyc", bus.cyc_count, 32'd1);
    idle();

    // Read path with stall hold.
    do_clear();
    bus.inst_retired = 1'b1;
    for (int i = 0; i < 42; i++) tick();
    idle();
    bus.wb_sel_m = 4'd7;
    tick();
    chk("rd_inst_42", bus.cnt_rdata_w, 32'd42);
    bus.stall        = 1'b1;
    bus.inst_retired = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold_42", bus.cnt_rdata_w, 32'd42);
    end
    chk("inst_45", bus.inst_count, 32'd45);
    idle();
    bus.wb_sel_m = 4'd2;
    tick();
    chk("rd_dmem_0", bus.cnt_rdata_w, 32'd0);

    // Wrap of the instruction counter.
    force dut.inst_q = 32'hFFFFFFFF;
    #1;
    release dut.inst_q;
    m_cnt[1] = 32'hFFFFFFFF;
    bus.inst_retired = 1'b1;
    bus.wb_sel_m     = 4'd7;
    tick();
    chk("inst_wrap", bus.inst_count, 32'd0);
    chk("rd_allones", bus.cnt_rdata_w, 32'hFFFFFFFF);
    idle();
    tick();

    // Fully random traffic including clearing, aliased and unrelated stores.
    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
